pio_host_port: RTL

- Responder side of the PIO host command bus (mindex/index/action/din -> dout/tx_full/rx_empty).
- Decodes host actions and owns the 32x16 instruction memory, the per-machine configuration registers and the per-machine TX/RX FIFOs.
- Serves the state-machine cores on the far side, which fetch instructions, read configuration and move FIFO data.
- Sits inside pio, between the host command bus and the four SM cores.

---
 rtl/pio_pkg.sv | 18 +
 rtl/pio_fifo.sv | 44 ++++
 rtl/pio_host_port.sv | 101 ++++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// pio_pkg: shared constants for the PIO host port (sizes, action codes, reset values)
package pio_pkg;
  localparam int NUM_SM     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int IMEM_DEPTH = 32;
  localparam logic [5:0] ACT_NOP         = 6'd0;
  localparam logic [5:0] ACT_INSTR_WRITE = 6'd1;
  localparam logic [5:0] ACT_ENABLE      = 6'd2;
  localparam logic [5:0] ACT_PULL        = 6'd3;
  localparam logic [5:0] ACT_PUSH        = 6'd4;
  localparam logic [5:0] ACT_CLKDIV      = 6'd5;
  localparam logic [5:0] ACT_PINCTRL     = 6'd6;
  localparam logic [5:0] ACT_EXECCTRL    = 6'd7;
  localparam logic [5:0] ACT_SHIFTCTRL   = 6'd8;
  localparam logic [5:0] ACT_RESTART     = 6'd9;
  localparam logic [5:0] ACT_ERRCLR      = 6'd10;
  localparam logic [31:0] CLKDIV_RST     = 32'h0001_0000;
endpackage

// File: rtl/pio_fifo.sv
// pio_fifo: first-word fall-through FIFO with flush and overflow/underflow strobes
// Ports: push/din in, pop/dout (head) out, full/empty status, ovf/unf single-cycle strobes.
module pio_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, rp_q;
  logic [W-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign empty   = wp_q == rp_q;
  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop  = pop && !empty && !flush;
  // a pop on a full FIFO frees the slot the same edge, so the push still lands
  assign do_push = push && !flush && (!full || do_pop);
  assign ovf     = push && !flush && full && !do_pop;
  assign unf     = pop && empty;
  assign dout    = mem_q[rp_q[AW-1:0]];
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (flush) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + (AW+1)'(1);
      if (do_pop) rp_q <= rp_q + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
endmodule

// File: rtl/pio_host_port.sv
// pio_host_port: host command decoder owning imem, per-machine config registers and TX/RX FIFOs
// Ports: host bus (mindex/index/action/din -> dout/tx_full/rx_empty); per-machine fetch
// (sm_pc/sm_instr), FIFO (sm_pull*/sm_push*), config, enable/restart and sticky error outputs.
module pio_host_port
  import pio_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [1:0]           mindex,
  input  logic [4:0]           index,
  input  logic [5:0]           action,
  input  logic [31:0]          din,
  output logic [31:0]          dout,
  output logic [NUM_SM-1:0]    tx_full,
  output logic [NUM_SM-1:0]    rx_empty,
  input  logic [NUM_SM*5-1:0]  sm_pc,
  output logic [NUM_SM*16-1:0] sm_instr,
  input  logic [NUM_SM-1:0]    sm_pull,
  output logic [NUM_SM*32-1:0] sm_pull_data,
  output logic [NUM_SM-1:0]    sm_tx_empty,
  input  logic [NUM_SM-1:0]    sm_push,
  input  logic [NUM_SM*32-1:0] sm_push_data,
  output logic [NUM_SM-1:0]    sm_rx_full,
  output logic [NUM_SM*32-1:0] clkdiv,
  output logic [NUM_SM*32-1:0] pinctrl,
  output logic [NUM_SM*32-1:0] execctrl,
  output logic [NUM_SM*32-1:0] shiftctrl,
  output logic [NUM_SM-1:0]    sm_enable,
  output logic [NUM_SM-1:0]    sm_restart,
  output logic [NUM_SM-1:0]    ovf_err,
  output logic [NUM_SM-1:0]    unf_err
);
  logic [15:0] imem_q [IMEM_DEPTH];
  logic [31:0] dout_q;
  logic [31:0] clkdiv_q [NUM_SM];
  logic [31:0] pinctrl_q [NUM_SM];
  logic [31:0] execctrl_q [NUM_SM];
  logic [31:0] shiftctrl_q [NUM_SM];
  logic [31:0] rx_head [NUM_SM];
  logic [NUM_SM-1:0] enable_q, restart_q, ovf_q, unf_q;
  logic [NUM_SM-1:0] sel, flush, host_push, host_pull, clr;
  logic [NUM_SM-1:0] tx_ovf, rx_ovf, rx_unf, tx_unf_unused;
  assign sel        = NUM_SM'(1) << mindex;
  assign flush      = action == ACT_RESTART ? din[NUM_SM-1:0] : '0;
  assign host_push  = action == ACT_PUSH ? sel : '0;
  assign host_pull  = action == ACT_PULL ? sel : '0;
  assign clr        = action == ACT_ERRCLR ? sel : '0;
  assign dout       = dout_q;
  assign sm_enable  = enable_q;
  assign sm_restart = restart_q;
  assign ovf_err    = ovf_q;
  assign unf_err    = unf_q;
  for (genvar i = 0; i < NUM_SM; i++) begin : g_sm
    pio_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_tx (
      .clk, .n_reset, .flush(flush[i]), .push(host_push[i]), .pop(sm_pull[i]), .din(din),
      .dout(sm_pull_data[i*32+:32]), .full(tx_full[i]), .empty(sm_tx_empty[i]),
      .ovf(tx_ovf[i]), .unf(tx_unf_unused[i])
    );
    pio_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_rx (
      .clk, .n_reset, .flush(flush[i]), .push(sm_push[i]), .pop(host_pull[i]),
      .din(sm_push_data[i*32+:32]), .dout(rx_head[i]), .full(sm_rx_full[i]),
      .empty(rx_empty[i]), .ovf(rx_ovf[i]), .unf(rx_unf[i])
    );
    // read-before-write: a same-cycle INSTR_WRITE is seen only after the edge
    assign sm_instr[i*16+:16]  = imem_q[sm_pc[i*5+:5]];
    assign clkdiv[i*32+:32]    = clkdiv_q[i];
    assign pinctrl[i*32+:32]   = pinctrl_q[i];
    assign execctrl[i*32+:32]  = execctrl_q[i];
    assign shiftctrl[i*32+:32] = shiftctrl_q[i];
  end
  always_ff @(posedge clk)
    if (action == ACT_INSTR_WRITE) imem_q[index] <= din[15:0];
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      dout_q    <= '0;
      enable_q  <= '0;
      restart_q <= '0;
      ovf_q     <= '0;
      unf_q     <= '0;
      for (int i = 0; i < NUM_SM; i++) begin
        clkdiv_q[i]    <= CLKDIV_RST;
        pinctrl_q[i]   <= '0;
        execctrl_q[i]  <= '0;
        shiftctrl_q[i] <= '0;
      end
    end else begin
      restart_q <= flush;
      if (action == ACT_ENABLE) enable_q <= din[NUM_SM-1:0];
      if (action == ACT_PULL && !rx_empty[mindex]) dout_q <= rx_head[mindex];
      // a new error in the same cycle as ERRCLR wins
      ovf_q <= (ovf_q & ~clr) | tx_ovf | rx_ovf;
      unf_q <= (unf_q & ~clr) | rx_unf;
      for (int i = 0; i < NUM_SM; i++)
        if (sel[i]) begin
          if (action == ACT_CLKDIV) clkdiv_q[i] <= din;
          if (action == ACT_PINCTRL) pinctrl_q[i] <= din;
          if (action == ACT_EXECCTRL) execctrl_q[i] <= din;
          if (action == ACT_SHIFTCTRL) shiftctrl_q[i] <= din;
        end
    end
endmodule
